// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU classes, branch kinds and the
// opcode-to-control decode table used by the ID stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;

  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI} ext_e;

  typedef struct packed {
    logic [2:0] aluop;
    logic       alusrc;
    ext_e       ext;
    logic       wr_rt;      // destination is rt rather than rd
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] branch;
    logic       rt_used;    // rt is a source operand (load-use check)
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c = '{aluop: ALU_ADD, alusrc: 1'b0, ext: EXT_SIGN, wr_rt: 1'b0,
          reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
          branch: BR_NONE, rt_used: 1'b0, illegal: 1'b0};
    case (op)
      OP_RTYPE: begin c.aluop = ALU_FUNCT; c.reg_write = 1'b1; c.rt_used = 1'b1; end
      OP_LW:    begin c.alusrc = 1'b1; c.wr_rt = 1'b1; c.reg_write = 1'b1; c.mem_read = 1'b1; end
      OP_SW:    begin c.alusrc = 1'b1; c.mem_write = 1'b1; c.rt_used = 1'b1; end
      OP_BEQ:   begin c.aluop = ALU_SUB; c.branch = BR_EQ; c.rt_used = 1'b1; end
      OP_BNE:   begin c.aluop = ALU_SUB; c.branch = BR_NE; c.rt_used = 1'b1; end
      OP_ADDI:  begin c.alusrc = 1'b1; c.wr_rt = 1'b1; c.reg_write = 1'b1; end
      OP_ANDI:  begin c.aluop = ALU_AND; c.alusrc = 1'b1; c.ext = EXT_ZERO; c.wr_rt = 1'b1; c.reg_write = 1'b1; end
      OP_ORI:   begin c.aluop = ALU_OR; c.alusrc = 1'b1; c.ext = EXT_ZERO; c.wr_rt = 1'b1; c.reg_write = 1'b1; end
      OP_SLTI:  begin c.aluop = ALU_SLT; c.alusrc = 1'b1; c.wr_rt = 1'b1; c.reg_write = 1'b1; end
      OP_LUI:   begin c.aluop = ALU_LUI; c.alusrc = 1'b1; c.ext = EXT_LUI; c.wr_rt = 1'b1; c.reg_write = 1'b1; end
      default:  c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] ext_imm(input ext_e e, input logic [15:0] imm);
    case (e)
      EXT_ZERO: return {16'h0, imm};
      EXT_LUI:  return {imm, 16'h0};
      default:  return {{16{imm[15]}}, imm};
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Architectural register file: two async read ports, one sync write port.
// r0 is hard-wired to zero; bypassing is handled by the parent.
module reg_file #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra0,
  output logic [31:0]   rd0,
  input  logic [AW-1:0] ra1,
  output logic [31:0]   rd1,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wd
);

  logic [31:0] mem [DEPTH];

  // Write port; reset wipes every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  assign rd0 = (ra0 == '0) ? '0 : mem[ra0];
  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];

endmodule

// File: rtl/decode_stage.sv
// ID stage + ID/EX register: decodes one instruction per handshake, reads
// operands with write-back bypass, and applies stall/flush/load-use interlock.
module decode_stage
  import mips_pkg::*;
#(
  parameter int          RF_DEPTH     = 32,
  parameter logic [31:0] RESET_PC_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_next_pc,
  input  logic        ex_ready,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [31:0] inputA,
  output logic [31:0] inputB,
  output logic [31:0] immediate,
  output logic [31:0] nextPC,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [2:0]  ALUop,
  output logic        ALUSrc,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  branch,
  output logic [4:0]  write_reg,
  output logic        illegal
);

  logic [4:0]  rs, rt, rd, dst;
  logic [31:0] rf_a, rf_b, opa, opb;
  logic        lu_stall, accept;
  ctrl_t       ctl;

  assign rs  = if_instr[25:21];
  assign rt  = if_instr[20:16];
  assign rd  = if_instr[15:11];
  assign ctl = decode(if_instr[31:26]);
  assign dst = ctl.reg_write ? (ctl.wr_rt ? rt : rd) : 5'd0;

  reg_file #(.DEPTH(RF_DEPTH), .AW(5)) u_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .ra0  (rs),
    .rd0  (rf_a),
    .ra1  (rt),
    .rd1  (rf_b),
    .we   (wb_en),
    .wa   (wb_addr),
    .wd   (wb_data)
  );

  // A write landing on the same edge as the accept must be visible.
  assign opa = (wb_en && wb_addr == rs && rs != 5'd0) ? wb_data : rf_a;
  assign opb = (wb_en && wb_addr == rt && rt != 5'd0) ? wb_data : rf_b;

  // Load in ID/EX whose destination feeds the incoming instruction.
  assign lu_stall = ex_valid && mem_read && write_reg != 5'd0 && if_valid &&
                    (rs == write_reg || (ctl.rt_used && rt == write_reg));

  assign if_ready = rst_n && (flush || ((!ex_valid || ex_ready) && !lu_stall));
  assign accept   = if_valid && if_ready;

  // ID/EX register: flush beats accept beats drain; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      inputA    <= '0;
      inputB    <= '0;
      immediate <= '0;
      nextPC    <= RESET_PC_VAL;
      shamt     <= '0;
      funct     <= '0;
      ALUop     <= '0;
      ALUSrc    <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      branch    <= BR_NONE;
      write_reg <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid  <= 1'b1;
      inputA    <= opa;
      inputB    <= opb;
      immediate <= ext_imm(ctl.ext, if_instr[15:0]);
      nextPC    <= if_next_pc;
      shamt     <= if_instr[10:6];
      funct     <= if_instr[5:0];
      ALUop     <= ctl.aluop;
      ALUSrc    <= ctl.alusrc;
      reg_write <= ctl.reg_write;
      mem_read  <= ctl.mem_read;
      mem_write <= ctl.mem_write;
      branch    <= ctl.branch;
      write_reg <= dst;
      illegal   <= ctl.illegal;
    end else if (ex_ready && ex_valid) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a behavioural model of the ID/EX contents
// checked every cycle, plus hand-computed literal checks of key results.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_ready, ex_ready, flush, wb_en;
  logic [31:0] if_instr, if_next_pc, wb_data;
  logic [4:0]  wb_addr;
  logic        ex_valid, ALUSrc, reg_write, mem_read, mem_write, illegal;
  logic [31:0] inputA, inputB, immediate, nextPC;
  logic [4:0]  shamt, write_reg;
  logic [5:0]  funct;
  logic [2:0]  ALUop;
  logic [1:0]  branch;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_next_pc(if_next_pc), .ex_ready(ex_ready),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .inputA(inputA), .inputB(inputB),
    .immediate(immediate), .nextPC(nextPC), .shamt(shamt), .funct(funct),
    .ALUop(ALUop), .ALUSrc(ALUSrc), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .write_reg(write_reg), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a, b, imm, pc;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [2:0]  aluop;
    logic        alusrc, rw, mr, mw;
    logic [1:0]  br;
    logic [4:0]  wr;
    logic        ill;
  } fld_t;

  // ---------------- behavioural model ----------------
  logic        m_valid = 1'b0;
  fld_t        m_f = '0;
  logic [31:0] m_rf [32];
  initial for (int i = 0; i < 32; i++) m_rf[i] = '0;

  function automatic logic [31:0] rd_reg(input logic [4:0] r);
    if (r == 0) return 0;
    if (wb_en && wb_addr == r) return wb_data;
    return m_rf[r];
  endfunction

  // Opcode table straight from the instruction-set description.
  function automatic fld_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    fld_t f;
    logic [31:0] sx, zx;
    logic [5:0] op;
    op = ins[31:26];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    f = '0;
    f.a = rd_reg(ins[25:21]);
    f.b = rd_reg(ins[20:16]);
    f.pc = pc;
    f.shamt = ins[10:6];
    f.funct = ins[5:0];
    f.imm = sx;
    case (op)
      6'h00: begin f.aluop = 3'd2; f.rw = 1; f.wr = ins[15:11]; end
      6'h23: begin f.alusrc = 1; f.rw = 1; f.mr = 1; f.wr = ins[20:16]; end
      6'h2B: begin f.alusrc = 1; f.mw = 1; end
      6'h04: begin f.aluop = 3'd1; f.br = 2'b01; end
      6'h05: begin f.aluop = 3'd1; f.br = 2'b10; end
      6'h08: begin f.alusrc = 1; f.rw = 1; f.wr = ins[20:16]; end
      6'h0C: begin f.aluop = 3'd3; f.alusrc = 1; f.imm = zx; f.rw = 1; f.wr = ins[20:16]; end
      6'h0D: begin f.aluop = 3'd4; f.alusrc = 1; f.imm = zx; f.rw = 1; f.wr = ins[20:16]; end
      6'h0A: begin f.aluop = 3'd5; f.alusrc = 1; f.rw = 1; f.wr = ins[20:16]; end
      6'h0F: begin f.aluop = 3'd6; f.alusrc = 1; f.imm = {ins[15:0], 16'h0}; f.rw = 1; f.wr = ins[20:16]; end
      default: f.ill = 1;
    endcase
    return f;
  endfunction

  function automatic logic model_ready();
    logic [5:0] op;
    logic rt_used, hit;
    op = if_instr[31:26];
    rt_used = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
    hit = m_valid && m_f.mr && m_f.wr != 0 && if_valid &&
          (if_instr[25:21] == m_f.wr || (rt_used && if_instr[20:16] == m_f.wr));
    return rst_n && (flush || ((!m_valid || ex_ready) && !hit));
  endfunction

  // Model state advance on each edge; register file written after reads.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_f <= '0;
      for (int i = 0; i < 32; i++) m_rf[i] <= '0;
    end else begin
      if (flush) m_valid <= 1'b0;
      else if (if_valid && model_ready()) begin
        m_valid <= 1'b1;
        m_f <= model_decode(if_instr, if_next_pc);
      end else if (ex_ready && m_valid) m_valid <= 1'b0;
      if (wb_en && wb_addr != 0) m_rf[wb_addr] <= wb_data;
    end
  end

  // Every-cycle comparison of the whole output bundle against the model.
  always @(negedge clk) begin
    fld_t act, exp;
    act = '{a: inputA, b: inputB, imm: immediate, pc: nextPC, shamt: shamt,
            funct: funct, aluop: ALUop, alusrc: ALUSrc, rw: reg_write,
            mr: mem_read, mw: mem_write, br: branch, wr: write_reg, ill: illegal};
    exp = m_f;
    if (exp.ill) begin
      act.aluop = 0; act.alusrc = 0; act.imm = 0;
      exp.aluop = 0; exp.alusrc = 0; exp.imm = 0;
    end
    checks++;
    if ({if_ready, ex_valid, act} !== {model_ready(), m_valid, exp}) begin
      errors++;
      $display("FAIL model_cmp t=%0t: got rdy=%b v=%b %h want rdy=%b v=%b %h",
               $time, if_ready, ex_valid, act, model_ready(), m_valid, exp);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    if_valid = 1; if_instr = ins; if_next_pc = pc;
    step();
    if_valid = 0;
  endtask

  initial begin
    rst_n = 0; if_valid = 0; if_instr = 0; if_next_pc = 0; ex_ready = 1;
    flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    #3;
    chk("rst_if_ready", {31'b0, if_ready}, 0);
    chk("rst_ex_valid", {31'b0, ex_valid}, 0);
    chk("rst_nextPC", nextPC, 0);
    step(); step();
    rst_n = 1;

    wb_en = 1; wb_addr = 1; wb_data = 78; step();
    wb_addr = 2; wb_data = 85; step();
    wb_en = 0;

    send(32'h00221020, 12);               // add r2,r1,r2
    chk("add_valid", {31'b0, ex_valid}, 1);
    chk("add_A", inputA, 78);
    chk("add_B", inputB, 85);
    chk("add_aluop", {29'b0, ALUop}, 2);
    chk("add_funct", {26'b0, funct}, 32'h20);
    chk("add_alusrc", {31'b0, ALUSrc}, 0);
    chk("add_wr", {27'b0, write_reg}, 2);
    chk("add_pc", nextPC, 12);

    send(32'h2023FFFE, 16);               // addi r3,r1,-2
    chk("addi_imm", immediate, 32'hFFFFFFFE);
    chk("addi_alusrc", {31'b0, ALUSrc}, 1);
    chk("addi_aluop", {29'b0, ALUop}, 0);
    chk("addi_wr", {27'b0, write_reg}, 3);
    send(32'h34088000, 20);               // ori r8,r0,0x8000
    chk("ori_imm", immediate, 32'h00008000);
    chk("ori_aluop", {29'b0, ALUop}, 4);
    send(32'h3C091234, 24);               // lui r9,0x1234
    chk("lui_imm", immediate, 32'h12340000);
    send(32'h302AFFFF, 28);               // andi r10,r1,0xFFFF
    chk("andi_imm", immediate, 32'h0000FFFF);
    send(32'h14220001, 32);               // bne r1,r2,1
    chk("bne_branch", {30'b0, branch}, 2);
    chk("bne_wr", {27'b0, write_reg}, 0);

    wb_en = 1; wb_addr = 6; wb_data = 32'h99;
    send(32'h00C03820, 36);               // add r7,r6,r0 with same-edge write
    wb_en = 0;
    chk("bypass_A", inputA, 32'h99);

    // Back-pressure: hold ID/EX for three cycles
    step();
    ex_ready = 0;
    send(32'h282B0005, 40);               // slti r11,r1,5
    chk("slti_imm", immediate, 5);
    if_valid = 1; if_instr = 32'hAC410004; if_next_pc = 44;   // sw r1,4(r2)
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", {31'b0, if_ready}, 0);
      chk("hold_imm", immediate, 5);
      chk("hold_pc", nextPC, 40);
      step();
    end
    ex_ready = 1;
    #1 chk("release_ready", {31'b0, if_ready}, 1);
    step();
    if_valid = 0;
    chk("sw_mw", {31'b0, mem_write}, 1);
    chk("sw_pc", nextPC, 44);
    chk("sw_wr", {27'b0, write_reg}, 0);

    // Load-use interlock
    send(32'h8C240000, 48);               // lw r4,0(r1)
    if_valid = 1; if_instr = 32'h00812820; if_next_pc = 52;   // add r5,r4,r1
    #1 chk("lu_stall_ready", {31'b0, if_ready}, 0);
    step();
    chk("lu_bubble", {31'b0, ex_valid}, 0);
    #1 chk("lu_ready_after", {31'b0, if_ready}, 1);
    step();
    if_valid = 0;
    chk("lu_accept_valid", {31'b0, ex_valid}, 1);
    chk("lu_accept_pc", nextPC, 52);

    // Flush kills ID/EX and the incoming beq
    if_valid = 1; if_instr = 32'h10220003; if_next_pc = 56; flush = 1;
    step();
    flush = 0; if_valid = 0;
    chk("flush_valid", {31'b0, ex_valid}, 0);
    chk("flush_pc", nextPC, 52);

    // r0 stays zero even with a write to it on the same edge
    wb_en = 1; wb_addr = 0; wb_data = 55;
    send(32'h00006020, 60);               // add r12,r0,r0
    wb_en = 0;
    chk("r0_bypass", inputA, 0);
    send(32'h00006020, 64);
    chk("r0_read", inputA, 0);

    send(32'hFC00F800, 68);               // opcode 0x3F
    chk("ill_flag", {31'b0, illegal}, 1);
    chk("ill_valid", {31'b0, ex_valid}, 1);
    chk("ill_ctrl", {26'b0, reg_write, mem_read, mem_write, branch, 1'b0}, 0);
    chk("ill_wr", {27'b0, write_reg}, 0);

    // Asynchronous reset in the middle of a stall
    ex_ready = 0;
    if_valid = 1; if_instr = 32'h00221020; if_next_pc = 72;
    step(); step();
    #2 rst_n = 0;
    #1;
    chk("arst_valid", {31'b0, ex_valid}, 0);
    chk("arst_illegal", {31'b0, illegal}, 0);
    chk("arst_pc", nextPC, 0);
    chk("arst_ready", {31'b0, if_ready}, 0);
    step();
    rst_n = 1; ex_ready = 1;
    send(32'h00221020, 12);
    chk("post_rst_valid", {31'b0, ex_valid}, 1);
    chk("post_rst_A", inputA, 0);
    chk("post_rst_B", inputB, 0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
